// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the IF
// stage and the memory controller. Lookups happen only in IDLE, so a fill and
// a lookup can never target the same line in the same cycle.
module inst_cache #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned ADDR_LEN   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                if_req_i,
  input  logic [ADDR_LEN-1:0] if_pc_i,
  input  logic                if_flush_i,
  output logic                if_inst_valid_o,
  output logic [31:0]         if_inst_o,
  output logic                mc_req_o,
  output logic [ADDR_LEN-1:0] mc_pc_o,
  input  logic                mc_inst_ready_i,
  input  logic [31:0]         mc_inst_i,
  output logic                busy_o
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = ADDR_LEN - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                  state;
  logic [LINES-1:0]        line_valid;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];

  logic [INDEX_BITS-1:0]   lu_idx;
  logic [TAG_W-1:0]        lu_tag;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic [TAG_W-1:0]        fill_tag;
  logic                    hit_c;
  logic                    fill_c;
  logic                    unused_pc_bits;

  // Address split: lookup uses the live PC, fills use the latched miss PC.
  assign lu_idx   = if_pc_i[INDEX_BITS+1:2];
  assign lu_tag   = if_pc_i[ADDR_LEN-1:INDEX_BITS+2];
  assign fill_idx = mc_pc_o[INDEX_BITS+1:2];
  assign fill_tag = mc_pc_o[ADDR_LEN-1:INDEX_BITS+2];
  assign unused_pc_bits = ^if_pc_i[1:0];

  assign hit_c  = line_valid[lu_idx] && (tag_mem[lu_idx] == lu_tag);
  // A returning word is always written once a miss is outstanding, even if the
  // fetch was cancelled, because it is still correct for the latched PC.
  assign fill_c = rdy && mc_inst_ready_i && (state != IDLE);

  // Tag/data arrays: no reset needed, the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_c) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mc_inst_i;
    end
  end

  // Control FSM with registered outputs and the valid-bit array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      line_valid      <= '0;
      if_inst_valid_o <= 1'b0;
      if_inst_o       <= 32'd0;
      mc_req_o        <= 1'b0;
      mc_pc_o         <= '0;
      busy_o          <= 1'b0;
    end else if (rdy) begin
      if_inst_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!if_flush_i && if_req_i) begin
            if (hit_c) begin
              if_inst_valid_o <= 1'b1;
              if_inst_o       <= data_mem[lu_idx];
            end else begin
              mc_req_o <= 1'b1;
              mc_pc_o  <= if_pc_i;
              busy_o   <= 1'b1;
              state    <= MISS;
            end
          end
        end
        MISS: begin
          if (mc_inst_ready_i) begin
            line_valid[fill_idx] <= 1'b1;
            mc_req_o             <= 1'b0;
            busy_o               <= 1'b0;
            state                <= IDLE;
            if (!if_flush_i) begin
              if_inst_valid_o <= 1'b1;
              if_inst_o       <= mc_inst_i;
            end
          end else if (if_flush_i) begin
            mc_req_o <= 1'b0;
            state    <= DROP;
          end
        end
        DROP: begin
          if (mc_inst_ready_i) begin
            line_valid[fill_idx] <= 1'b1;
            busy_o               <= 1'b0;
            state                <= IDLE;
          end
        end
        default: begin
          mc_req_o <= 1'b0;
          busy_o   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a per-cycle vector table plus a hand-written
// asynchronous-reset sequence.
module tb_inst_cache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        if_req_i;
  logic [31:0] if_pc_i;
  logic        if_flush_i;
  logic        if_inst_valid_o;
  logic [31:0] if_inst_o;
  logic        mc_req_o;
  logic [31:0] mc_pc_o;
  logic        mc_inst_ready_i;
  logic [31:0] mc_inst_i;
  logic        busy_o;

  int checks;
  int failures;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] pc;
    logic        flush;
    logic        ready;
    logic [31:0] inst;
    logic        e_valid;
    logic [31:0] e_inst;
    logic        e_mc_req;
    logic [31:0] e_mc_pc;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  inst_cache dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .if_req_i        (if_req_i),
    .if_pc_i         (if_pc_i),
    .if_flush_i      (if_flush_i),
    .if_inst_valid_o (if_inst_valid_o),
    .if_inst_o       (if_inst_o),
    .mc_req_o        (mc_req_o),
    .mc_pc_o         (mc_pc_o),
    .mc_inst_ready_i (mc_inst_ready_i),
    .mc_inst_i       (mc_inst_i),
    .busy_o          (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic q, logic [31:0] p, logic f,
                              logic rd, logic [31:0] d, logic ev,
                              logic [31:0] ei, logic em, logic [31:0] ep,
                              logic eb);
    vec_t v;
    v.rdy = r; v.req = q; v.pc = p; v.flush = f; v.ready = rd; v.inst = d;
    v.e_valid = ev; v.e_inst = ei; v.e_mc_req = em; v.e_mc_pc = ep;
    v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] ei,
                         input logic em, input logic [31:0] ep, input logic eb);
    chk({tag, ".valid"},  32'(if_inst_valid_o), 32'(ev));
    chk({tag, ".inst"},   if_inst_o, ei);
    chk({tag, ".mc_req"}, 32'(mc_req_o), 32'(em));
    chk({tag, ".mc_pc"},  mc_pc_o, ep);
    chk({tag, ".busy"},   32'(busy_o), 32'(eb));
  endtask

  task automatic drive(input logic r, input logic q, input logic [31:0] p,
                       input logic f, input logic rd, input logic [31:0] d);
    rdy = r; if_req_i = q; if_pc_i = p; if_flush_i = f;
    mc_inst_ready_i = rd; mc_inst_i = d;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    //          rdy  req  pc        fl   rdy_i inst         | val  inst         mreq mc_pc     busy
    // cold miss, fill, then hits
    vecs.push_back(mk(1, 1, 32'h100, 0, 0, 32'h0,        0, 32'h0,        1, 32'h100, 1));
    vecs.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,        1, 32'h100, 1));
    vecs.push_back(mk(1, 0, 32'h0,   0, 1, 32'h00500093, 1, 32'h00500093, 0, 32'h100, 0));
    vecs.push_back(mk(1, 1, 32'h100, 0, 0, 32'h0,        1, 32'h00500093, 0, 32'h100, 0));
    vecs.push_back(mk(1, 1, 32'h100, 0, 0, 32'h0,        1, 32'h00500093, 0, 32'h100, 0));
    vecs.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,        0, 32'h00500093, 0, 32'h100, 0));
    // conflict on index 0: 0x200 evicts 0x100; if_req ignored during MISS
    vecs.push_back(mk(1, 1, 32'h200, 0, 0, 32'h0,        0, 32'h00500093, 1, 32'h200, 1));
    vecs.push_back(mk(1, 1, 32'h100, 0, 1, 32'h11111111, 1, 32'h11111111, 0, 32'h200, 0));
    vecs.push_back(mk(1, 1, 32'h100, 0, 0, 32'h0,        0, 32'h11111111, 1, 32'h100, 1));
    vecs.push_back(mk(1, 0, 32'h0,   0, 1, 32'h22222222, 1, 32'h22222222, 0, 32'h100, 0));
    // ready pulse in IDLE is ignored
    vecs.push_back(mk(1, 0, 32'h0,   0, 1, 32'hDEADBEEF, 0, 32'h22222222, 0, 32'h100, 0));
    // flush in MISS -> DROP, fill without valid pulse, later hit
    vecs.push_back(mk(1, 1, 32'h40,  0, 0, 32'h0,        0, 32'h22222222, 1, 32'h40,  1));
    vecs.push_back(mk(1, 0, 32'h0,   1, 0, 32'h0,        0, 32'h22222222, 0, 32'h40,  1));
    vecs.push_back(mk(1, 0, 32'h0,   1, 0, 32'h0,        0, 32'h22222222, 0, 32'h40,  1));
    vecs.push_back(mk(1, 0, 32'h0,   0, 1, 32'h13,       0, 32'h22222222, 0, 32'h40,  0));
    vecs.push_back(mk(1, 1, 32'h40,  0, 0, 32'h0,        1, 32'h13,       0, 32'h40,  0));
    // flush beats req in IDLE
    vecs.push_back(mk(1, 1, 32'h40,  1, 0, 32'h0,        0, 32'h13,       0, 32'h40,  0));
    // flush and ready together in MISS: write, no pulse, back to IDLE
    vecs.push_back(mk(1, 1, 32'h44,  0, 0, 32'h0,        0, 32'h13,       1, 32'h44,  1));
    vecs.push_back(mk(1, 0, 32'h0,   1, 1, 32'h55,       0, 32'h13,       0, 32'h44,  0));
    vecs.push_back(mk(1, 1, 32'h44,  0, 0, 32'h0,        1, 32'h55,       0, 32'h44,  0));
    // rdy low freezes a MISS even with ready asserted
    vecs.push_back(mk(1, 1, 32'h80,  0, 0, 32'h0,        0, 32'h55,       1, 32'h80,  1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h66,       0, 32'h55,       1, 32'h80,  1));
    vecs.push_back(mk(0, 0, 32'h0,   0, 1, 32'h66,       0, 32'h55,       1, 32'h80,  1));
    vecs.push_back(mk(0, 1, 32'h80,  0, 1, 32'h66,       0, 32'h55,       1, 32'h80,  1));
    vecs.push_back(mk(1, 0, 32'h0,   0, 1, 32'h66,       1, 32'h66,       0, 32'h80,  0));
    vecs.push_back(mk(1, 1, 32'h80,  0, 0, 32'h0,        1, 32'h66,       0, 32'h80,  0));

    // reset state
    #12;
    chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rdy, vecs[i].req, vecs[i].pc, vecs[i].flush,
            vecs[i].ready, vecs[i].inst);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_inst,
              vecs[i].e_mc_req, vecs[i].e_mc_pc, vecs[i].e_busy);
    end

    // async reset mid-MISS takes effect before the next edge
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk_all("miss300", 1'b0, 32'h66, 1'b1, 32'h300, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // previously-hitting pc 0x80 now misses
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk_all("post_rst", 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77);
    @(posedge clk);
    #1;
    chk_all("post_rst_fill", 1'b1, 32'h77, 1'b0, 32'h80, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 SHALL parameter INDEX_BITS, default 6, log2 of line count; 64 direct-mapped one-word lines.
REQ-002 SHALL parameter ADDR_LEN, default 32, PC width; tag = pc[ADDR_LEN-1:INDEX_BITS+2], index = pc[INDEX_BITS+1:2], pc[1:0] ignored.
REQ-003 SHALL port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL port rdy  in  1  global enable; low = every register holds, all inputs ignored.
REQ-006 SHALL port if_req_i  in  1  fetch request from IF stage.
REQ-007 SHALL port if_pc_i  in  ADDR_LEN  fetch address.
REQ-008 SHALL port if_flush_i  in  1  PC redirect (jump/branch); cancels current fetch.
REQ-009 SHALL port if_inst_valid_o  out  1  one-cycle pulse, if_inst_o valid.
REQ-010 SHALL port if_inst_o  out  32  fetched instruction.
REQ-011 SHALL port mc_req_o  out  1  miss request to memory controller (its IF-enable input).
REQ-012 SHALL port mc_pc_o  out  ADDR_LEN  miss address.
REQ-013 SHALL port mc_inst_ready_i  in  1  one-cycle pulse, memory controller finished fetch.
REQ-014 SHALL port mc_inst_i  in  32  instruction from memory controller, valid with mc_inst_ready_i.
REQ-015 SHALL port busy_o  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, MISS, DROP; all outputs registered.
REQ-017 IDLE, if_flush_i=1: no lookup, if_inst_valid_o cleared next edge, remain IDLE; flush has priority over if_req_i.
REQ-018 IDLE, if_req_i=1, line valid and tag equal (hit): next edge if_inst_valid_o=1, if_inst_o=line data, remain IDLE; hit latency 1 cycle; back-to-back hits every cycle.
REQ-019 IDLE, if_req_i=1, miss: next edge latch pc, mc_req_o=1, mc_pc_o=pc, go MISS, if_inst_valid_o=0.
REQ-020 MISS: mc_req_o and mc_pc_o held stable; if_req_i ignored.
REQ-021 MISS, mc_inst_ready_i=1, no flush: write line (valid=1, tag, mc_inst_i); next edge if_inst_valid_o=1, if_inst_o=mc_inst_i, mc_req_o=0, go IDLE.
REQ-022 MISS, if_flush_i=1, no ready: mc_req_o=0 next edge, go DROP; once mc_req_o has been high one cycle the controller is committed to exactly one ready pulse.
REQ-023 MISS, if_flush_i and mc_inst_ready_i same cycle: line written, no if_inst_valid_o, go IDLE.
REQ-024 DROP: wait for mc_inst_ready_i; on it write line (data is correct for latched pc), no if_inst_valid_o, go IDLE; flushes in DROP have no further effect.
REQ-025 if_inst_valid_o SHALL never be high for two consecutive cycles from one request; never high in cycle after a flush.
REQ-026 Fill and hit lookup to same index in same cycle cannot occur (IDLE-only lookup); no bypass needed.
REQ-027 mc_inst_ready_i in IDLE SHALL be ignored (no write, no output).

Reset
REQ-028 rst low SHALL immediately force: state IDLE, all valid bits 0, if_inst_valid_o=0, if_inst_o=0, mc_req_o=0, mc_pc_o=0, busy_o=0; tag/data arrays need not reset.
REQ-029 reset mid-MISS/DROP SHALL abandon the transaction; memory controller resets by same rst.

Verification
REQ-030 cold miss: req pc 0x100 -> next cycle mc_req_o=1, mc_pc_o=0x100; ready with 0x00500093 -> next cycle valid=1, inst=0x00500093; re-req 0x100 -> valid after 1 cycle, mc_req_o stays 0.
REQ-031 conflict: fill 0x100, then 0x200 (same index 0) -> miss and refill; req 0x100 again -> miss, mc_pc_o=0x100.
REQ-032 flush in MISS: req 0x40, flush next cycle -> DROP, mc_req_o=0; ready 0x13 -> no valid pulse; req 0x40 then hits with 0x13.
REQ-033 rdy low 3 cycles during MISS with ready pulse asserted -> no state change, no output; rdy high -> completes normally.
REQ-034 async reset asserted mid-cycle in MISS -> mc_req_o=0, busy_o=0 before next edge; prior-hit pc now misses.
